// File: rtl/wb_retire_queue_if.sv
// rtl/wb_retire_queue_if.sv - MEM-side enqueue bus and head-side retire/write ports of the WB retire queue
interface wb_retire_queue_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_pc;
  logic [RD_W-1:0] in_rd;
  logic            in_rf_wen;
  logic            in_csr_wen;
  logic [11:0]     in_csr_addr;
  logic [1:0]      in_sel;
  logic [2:0]      in_ld_type;
  logic [1:0]      in_byte_off;
  logic [31:0]     in_mem_data;
  logic [31:0]     in_alu;
  logic [31:0]     in_csr_rdata;

  logic            retire_ready;
  logic            retire_valid;
  logic [31:0]     retire_pc;
  logic            rf_wen;
  logic [RD_W-1:0] rf_waddr;
  logic [31:0]     rf_wdata;
  logic            csr_wen;
  logic [11:0]     csr_waddr;
  logic [31:0]     csr_wdata;
  logic            byp_valid;
  logic [RD_W-1:0] byp_rd;
  logic [31:0]     byp_data;

  modport slave (
    input  in_valid, in_pc, in_rd, in_rf_wen, in_csr_wen, in_csr_addr, in_sel,
           in_ld_type, in_byte_off, in_mem_data, in_alu, in_csr_rdata, retire_ready,
    output in_ready, retire_valid, retire_pc, rf_wen, rf_waddr, rf_wdata,
           csr_wen, csr_waddr, csr_wdata, byp_valid, byp_rd, byp_data
  );

  modport master (
    output in_valid, in_pc, in_rd, in_rf_wen, in_csr_wen, in_csr_addr, in_sel,
           in_ld_type, in_byte_off, in_mem_data, in_alu, in_csr_rdata, retire_ready,
    input  in_ready, retire_valid, retire_pc, rf_wen, rf_waddr, rf_wdata,
           csr_wen, csr_waddr, csr_wdata, byp_valid, byp_rd, byp_data
  );
endinterface

// File: rtl/wb_retire_queue.sv
// rtl/wb_retire_queue.sv - in-order writeback/retire queue with load alignment and result select at enqueue
module wb_retire_queue #(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  wb_retire_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic [31:0]     pc_q      [DEPTH];
  logic [RD_W-1:0] rd_q      [DEPTH];
  logic            rf_wen_q  [DEPTH];
  logic            csr_wen_q [DEPTH];
  logic [11:0]     csr_adr_q [DEPTH];
  logic [31:0]     gpr_q     [DEPTH];
  logic [31:0]     alu_q     [DEPTH];

  logic        enq, deq;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] gpr_val;

  assign bus.in_ready     = (count_q != (PW+1)'(DEPTH));
  assign bus.retire_valid = (count_q != '0);
  assign enq = bus.in_valid && bus.in_ready;
  assign deq = bus.retire_valid && bus.retire_ready;

  always_comb begin
    ld_byte = bus.in_mem_data[7:0];
    case (bus.in_byte_off)
      2'd1:    ld_byte = bus.in_mem_data[15:8];
      2'd2:    ld_byte = bus.in_mem_data[23:16];
      2'd3:    ld_byte = bus.in_mem_data[31:24];
      default: ld_byte = bus.in_mem_data[7:0];
    endcase
    ld_half = bus.in_byte_off[1] ? bus.in_mem_data[31:16] : bus.in_mem_data[15:0];
    // Unlisted funct3 codes fall through to the full word.
    case (bus.in_ld_type)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = bus.in_mem_data;
    endcase
    case (bus.in_sel)
      2'b01:   gpr_val = ld_val;
      2'b10:   gpr_val = bus.in_csr_rdata;
      2'b11:   gpr_val = bus.in_pc + 32'd4;
      default: gpr_val = bus.in_alu;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is deliberately left unreset; count alone decides what is live.
  always_ff @(posedge clock) begin
    if (enq && reset) begin
      pc_q[wr_ptr_q]      <= bus.in_pc;
      rd_q[wr_ptr_q]      <= bus.in_rd;
      rf_wen_q[wr_ptr_q]  <= bus.in_rf_wen;
      csr_wen_q[wr_ptr_q] <= bus.in_csr_wen;
      csr_adr_q[wr_ptr_q] <= bus.in_csr_addr;
      gpr_q[wr_ptr_q]     <= gpr_val;
      alu_q[wr_ptr_q]     <= bus.in_alu;
    end
  end

  always_comb begin
    bus.retire_pc = '0;
    bus.rf_wen    = 1'b0;
    bus.rf_waddr  = '0;
    bus.rf_wdata  = '0;
    bus.csr_wen   = 1'b0;
    bus.csr_waddr = '0;
    bus.csr_wdata = '0;
    bus.byp_valid = 1'b0;
    bus.byp_rd    = '0;
    bus.byp_data  = '0;
    if (bus.retire_valid) begin
      bus.retire_pc = pc_q[rd_ptr_q];
      bus.rf_waddr  = rd_q[rd_ptr_q];
      bus.rf_wdata  = gpr_q[rd_ptr_q];
      bus.csr_waddr = csr_adr_q[rd_ptr_q];
      bus.csr_wdata = alu_q[rd_ptr_q];
      bus.byp_rd    = rd_q[rd_ptr_q];
      bus.byp_data  = gpr_q[rd_ptr_q];
      bus.byp_valid = rf_wen_q[rd_ptr_q] && (rd_q[rd_ptr_q] != '0);
      bus.rf_wen    = bus.byp_valid && bus.retire_ready;
      bus.csr_wen   = csr_wen_q[rd_ptr_q] && bus.retire_ready;
    end
  end
endmodule

// File: tb/tb_wb_retire_queue.sv
// tb/tb_wb_retire_queue.sv - scoreboard bench for wb_retire_queue with directed and random traffic
module tb_wb_retire_queue;
  localparam int DEPTH = 2;
  localparam int RD_W  = 5;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rf_wen;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [1:0]  sel;
    logic [2:0]  ld_type;
    logic [1:0]  off;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] csr_rdata;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] wdata;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] alu;
  } exp_t;

  logic clock;
  logic reset;
  wb_retire_queue_if #(.RD_W(RD_W)) bus ();

  wb_retire_queue #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   retires  = 0;
  bit   rr_rand  = 0;
  exp_t sb[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] v;
    logic [31:0] ld;
    v = s.mem;
    if (s.ld_type == 3'd0 || s.ld_type == 3'd4) begin
      ld = (v >> (8 * s.off)) & 32'hFF;
      if (s.ld_type == 3'd0 && ld >= 32'h80) ld = ld | 32'hFFFF_FF00;
    end else if (s.ld_type == 3'd1 || s.ld_type == 3'd5) begin
      ld = (v >> (16 * (s.off / 2))) & 32'hFFFF;
      if (s.ld_type == 3'd1 && ld >= 32'h8000) ld = ld | 32'hFFFF_0000;
    end else begin
      ld = v;
    end
    e.pc       = s.pc;
    e.rd       = s.rd;
    e.wr       = s.rf_wen && (s.rd != 0);
    e.wdata    = (s.sel == 2'd0) ? s.alu : (s.sel == 2'd1) ? ld :
                 (s.sel == 2'd2) ? s.csr_rdata : s.pc + 32'd4;
    e.csr_wen  = s.csr_wen;
    e.csr_addr = s.csr_addr;
    e.alu      = s.alu;
    return e;
  endfunction

  // Monitor: sb holds exactly what the DUT should contain at each falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("retire_valid", 32'(bus.retire_valid), 32'(sb.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(sb.size() != DEPTH));
        if (sb.size() != 0 && bus.retire_valid) begin
          chk("retire_pc", bus.retire_pc, sb[0].pc);
          chk("rf_waddr", 32'(bus.rf_waddr), 32'(sb[0].rd));
          chk("rf_wdata", bus.rf_wdata, sb[0].wdata);
          chk("rf_wen", 32'(bus.rf_wen), 32'(sb[0].wr && bus.retire_ready));
          chk("csr_wen", 32'(bus.csr_wen), 32'(sb[0].csr_wen && bus.retire_ready));
          chk("csr_waddr", 32'(bus.csr_waddr), 32'(sb[0].csr_addr));
          chk("csr_wdata", bus.csr_wdata, sb[0].alu);
          chk("byp_valid", 32'(bus.byp_valid), 32'(sb[0].wr));
          chk("byp_rd", 32'(bus.byp_rd), 32'(sb[0].rd));
          chk("byp_data", bus.byp_data, sb[0].wdata);
          if (bus.retire_ready) begin
            void'(sb.pop_front());
            retires++;
          end
        end else if (sb.size() == 0) begin
          chk("empty_outs", {bus.retire_pc[15:0], bus.rf_wdata[7:0], 3'(bus.rf_waddr),
                             bus.rf_wen, bus.csr_wen, bus.byp_valid, 2'(bus.byp_data)},
              32'h0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rr_rand) bus.retire_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_inputs(input stim_t s);
    bus.in_valid     = 1'b1;
    bus.in_pc        = s.pc;
    bus.in_rd        = s.rd;
    bus.in_rf_wen    = s.rf_wen;
    bus.in_csr_wen   = s.csr_wen;
    bus.in_csr_addr  = s.csr_addr;
    bus.in_sel       = s.sel;
    bus.in_ld_type   = s.ld_type;
    bus.in_byte_off  = s.off;
    bus.in_mem_data  = s.mem;
    bus.in_alu       = s.alu;
    bus.in_csr_rdata = s.csr_rdata;
  endtask

  // Returns just after the falling edge of the cycle in which the item is accepted.
  task automatic drive_item(input stim_t s, input int max_wait, output int waited);
    bit done;
    @(posedge clock);
    #1;
    set_inputs(s);
    waited = 0;
    done   = 0;
    while (!done) begin
      @(negedge clock);
      #1;
      if (reset && bus.in_ready) begin
        sb.push_back(model(s));
        done = 1;
      end else begin
        waited++;
        if (waited > max_wait) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout pc=%h waited=%0d", s.pc, waited);
          bus.in_valid = 1'b0;
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    rr_rand = 0;
    bus.retire_ready = 1'b1;
    n = 0;
    while (bus.retire_valid && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("drain", 32'(bus.retire_valid), 32'h0);
  endtask

  function automatic stim_t base_stim(input logic [31:0] pc);
    stim_t s;
    s.pc = pc; s.rd = 5'd5; s.rf_wen = 1'b1; s.csr_wen = 1'b0; s.csr_addr = 12'h0;
    s.sel = 2'b01; s.ld_type = 3'b010; s.off = 2'd0; s.mem = 32'h0;
    s.alu = 32'h0; s.csr_rdata = 32'h0;
    return s;
  endfunction

  task automatic load_test(input string name, input logic [31:0] mem, input logic [1:0] off,
                           input logic [2:0] ty, input logic [31:0] expv);
    stim_t s;
    int    w;
    s = base_stim(32'h8000_0000 + 32'($urandom_range(0, 255) * 4));
    s.mem = mem; s.off = off; s.ld_type = ty;
    bus.retire_ready = 1'b1;
    drive_item(s, 5, w);
    idle();
    @(negedge clock);
    #1;
    chk({name, "_valid"}, 32'(bus.retire_valid), 32'h1);
    chk({name, "_waddr"}, 32'(bus.rf_waddr), 32'd5);
    chk({name, "_wdata"}, bus.rf_wdata, expv);
  endtask

  initial begin
    stim_t s;
    int    w;
    int    r0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_rd = '0; bus.in_rf_wen = 1'b0;
    bus.in_csr_wen = 1'b0; bus.in_csr_addr = '0; bus.in_sel = '0; bus.in_ld_type = '0;
    bus.in_byte_off = '0; bus.in_mem_data = '0; bus.in_alu = '0; bus.in_csr_rdata = '0;
    bus.retire_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_retire_valid", 32'(bus.retire_valid), 32'h0);
    chk("rst_outs", {bus.rf_wen, bus.csr_wen, bus.byp_valid, 29'(bus.rf_wdata)}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    load_test("lb_off1", 32'h80F1_7F23, 2'd1, 3'b000, 32'h0000_007F);
    load_test("lb_off3", 32'h80F1_7F23, 2'd3, 3'b000, 32'hFFFF_FF80);
    load_test("lhu_off2", 32'h8001_1234, 2'd2, 3'b101, 32'h0000_8001);
    load_test("lh_off2", 32'h8001_1234, 2'd2, 3'b001, 32'hFFFF_8001);
    load_test("lh_off3", 32'h8001_1234, 2'd3, 3'b001, 32'hFFFF_8001);
    load_test("lbu_off3", 32'h80F1_7F23, 2'd3, 3'b100, 32'h0000_0080);
    load_test("lh_off1", 32'h0001_F234, 2'd1, 3'b001, 32'hFFFF_F234);
    load_test("undef_lw", 32'hDEAD_BEEF, 2'd1, 3'b111, 32'hDEAD_BEEF);
    drain();

    // Backpressure: two accepts fill the queue, third waits for the first retire.
    bus.retire_ready = 1'b0;
    drive_item(base_stim(32'h100), 5, w);
    drive_item(base_stim(32'h104), 5, w);
    @(posedge clock);
    #1;
    set_inputs(base_stim(32'h108));
    @(negedge clock);
    chk("bp_full", 32'(bus.in_ready), 32'h0);
    @(posedge clock);
    #1;
    bus.retire_ready = 1'b1;
    @(negedge clock);
    chk("bp_still_full", 32'(bus.in_ready), 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("bp_reopen", 32'(bus.in_ready), 32'h1);
    #1;
    if (bus.in_ready) sb.push_back(model(base_stim(32'h108)));
    drain();

    // Streaming at one instruction per cycle.
    r0 = retires;
    bus.retire_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s = base_stim(32'h200 + 32'(i * 4));
      s.sel = 2'b11;
      drive_item(s, 5, w);
      if (i > 0) begin
        chk("stream_wait", 32'(w), 32'h0);
        chk("stream_head", 32'(bus.retire_valid), 32'h1);
      end
    end
    drain();
    chk("stream_retires", 32'(retires - r0), 32'd10);

    // rd=0 never writes or forwards.
    s = base_stim(32'h300);
    s.rd = 5'd0; s.sel = 2'b00; s.alu = 32'h1234;
    drive_item(s, 5, w);
    idle();
    @(negedge clock);
    #1;
    chk("x0_valid", 32'(bus.retire_valid), 32'h1);
    chk("x0_rf_wen", 32'(bus.rf_wen), 32'h0);
    chk("x0_byp", 32'(bus.byp_valid), 32'h0);

    s = base_stim(32'h304);
    s.csr_wen = 1'b1; s.csr_addr = 12'h305; s.alu = 32'h8000_0000; s.sel = 2'b10;
    s.csr_rdata = 32'h0000_1800;
    drive_item(s, 5, w);
    idle();
    @(negedge clock);
    #1;
    chk("csr_wen", 32'(bus.csr_wen), 32'h1);
    chk("csr_waddr_d", 32'(bus.csr_waddr), 32'h305);
    chk("csr_wdata_d", bus.csr_wdata, 32'h8000_0000);
    chk("csr_rf_wdata", bus.rf_wdata, 32'h0000_1800);
    drain();

    // Reset mid-cycle with two queued entries.
    bus.retire_ready = 1'b0;
    drive_item(base_stim(32'h400), 5, w);
    drive_item(base_stim(32'h404), 5, w);
    idle();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.retire_valid), 32'h0);
    chk("mid_rst_rf_wen", 32'(bus.rf_wen), 32'h0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_data", bus.rf_wdata, 32'h0);
    sb.delete();
    bus.retire_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_valid", 32'(bus.retire_valid), 32'h0);
    chk("post_rst_ready", 32'(bus.in_ready), 32'h1);

    // Random traffic with random retire backpressure.
    rr_rand = 1;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] types [8];
      types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      s.pc        = $urandom;
      s.rd        = 5'($urandom);
      s.rf_wen    = 1'($urandom);
      s.csr_wen   = 1'($urandom);
      s.csr_addr  = 12'($urandom);
      s.sel       = 2'($urandom);
      s.ld_type   = types[$urandom_range(0, 7)];
      s.off       = 2'($urandom);
      s.mem       = $urandom;
      s.alu       = $urandom;
      s.csr_rdata = $urandom;
      if ($urandom_range(0, 3) == 0) idle();
      drive_item(s, 200, w);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
